// File: rtl/fp_fma_pkg.sv
// rtl/fp_fma_pkg.sv - shared constants and operand class type for the FMA special-case pipe
package fp_fma_pkg;

  localparam int WIDTH      = 16;
  localparam int CWIDTH     = 32;
  localparam int EXP_WIDTH  = 8;
  localparam int SIG_WIDTH  = 7;
  localparam int CSIG_WIDTH = 23;

  // Canonical quiet NaN returned for every NaN-producing case
  localparam logic [31:0] CANON_QNAN = 32'h7FC00000;

  typedef enum logic [2:0] {
    ZERO,
    SUB,
    NORM,
    INF,
    QNAN,
    SNAN
  } fp_class_t;

endpackage

// File: rtl/fp_classify_lane.sv
// rtl/fp_classify_lane.sv - combinational IEEE-754 class and sign decode of one operand
module fp_classify_lane
  import fp_fma_pkg::*;
#(
  parameter int TOTAL_WIDTH = 16,
  parameter int SIG_W       = 7
) (
  input  logic [TOTAL_WIDTH-1:0] operand,
  output fp_class_t              cls,
  output logic                   sign
);

  localparam int EXP_W = TOTAL_WIDTH - SIG_W - 1;

  logic [EXP_W-1:0] expField;
  logic [SIG_W-1:0] sigField;

  assign sign     = operand[TOTAL_WIDTH-1];
  assign expField = operand[TOTAL_WIDTH-2 -: EXP_W];
  assign sigField = operand[SIG_W-1:0];

  // Exponent extremes select the special classes; the mantissa MSB is the quiet bit
  always_comb begin
    if (&expField) begin
      if (sigField == '0)          cls = INF;
      else if (sigField[SIG_W-1])  cls = QNAN;
      else                         cls = SNAN;
    end else if (expField == '0) begin
      cls = (sigField == '0) ? ZERO : SUB;
    end else begin
      cls = NORM;
    end
  end

endmodule

// File: rtl/fp_fma_special_pipe.sv
// rtl/fp_fma_special_pipe.sv - multi-lane FMA special-case resolver pipe; FP_SPECIAL_FTZ_EN flushes subnormals to zero
module fp_fma_special_pipe #(
  parameter int WIDTH      = 16,
  parameter int CWIDTH     = 32,
  parameter int EXP_WIDTH  = 8,
  parameter int SIG_WIDTH  = 7,
  parameter int CSIG_WIDTH = 23,
  parameter int LANES      = 4,
  parameter int STAGES     = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*WIDTH-1:0]  a,
  input  logic [LANES*WIDTH-1:0]  b,
  input  logic [LANES*CWIDTH-1:0] c,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        special_hit,
  output logic [LANES*CWIDTH-1:0] special_result,
  output logic [LANES-1:0]        lane_invalid,
  input  logic                    clear_flags,
  output logic                    sticky_invalid,
  output logic                    sticky_inf,
  output logic [CNT_WIDTH-1:0]    invalid_count
);

`ifdef FP_SPECIAL_FTZ_EN
  localparam bit FTZ = 1'b1;
`else
  localparam bit FTZ = 1'b0;
`endif

  logic [LANES-1:0]        hitComb;
  logic [LANES-1:0]        invComb;
  logic [LANES*CWIDTH-1:0] resComb;
  logic [LANES-1:0]        laneInf;

  for (genvar i = 0; i < LANES; i++) begin : gLane
    fp_fma_pkg::fp_class_t clsA, clsB, clsC;
    logic sA, sB, sC, sp;
    logic aNan, bNan, cNan, anySnan;
    logic aInf, bInf, cInf, aZero, bZero, cZero;
    logic [CWIDTH-1:0] res;
    logic hit, inv;

    fp_classify_lane #(.TOTAL_WIDTH(WIDTH), .SIG_W(SIG_WIDTH)) uClsA (
      .operand(a[i*WIDTH +: WIDTH]), .cls(clsA), .sign(sA));
    fp_classify_lane #(.TOTAL_WIDTH(WIDTH), .SIG_W(SIG_WIDTH)) uClsB (
      .operand(b[i*WIDTH +: WIDTH]), .cls(clsB), .sign(sB));
    fp_classify_lane #(.TOTAL_WIDTH(CWIDTH), .SIG_W(CSIG_WIDTH)) uClsC (
      .operand(c[i*CWIDTH +: CWIDTH]), .cls(clsC), .sign(sC));

    assign sp      = sA ^ sB;
    assign aNan    = (clsA == fp_fma_pkg::QNAN) || (clsA == fp_fma_pkg::SNAN);
    assign bNan    = (clsB == fp_fma_pkg::QNAN) || (clsB == fp_fma_pkg::SNAN);
    assign cNan    = (clsC == fp_fma_pkg::QNAN) || (clsC == fp_fma_pkg::SNAN);
    assign anySnan = (clsA == fp_fma_pkg::SNAN) || (clsB == fp_fma_pkg::SNAN) ||
                     (clsC == fp_fma_pkg::SNAN);
    assign aInf    = clsA == fp_fma_pkg::INF;
    assign bInf    = clsB == fp_fma_pkg::INF;
    assign cInf    = clsC == fp_fma_pkg::INF;
    // Under flush-to-zero a subnormal behaves exactly like a signed zero
    assign aZero   = (clsA == fp_fma_pkg::ZERO) || (FTZ && clsA == fp_fma_pkg::SUB);
    assign bZero   = (clsB == fp_fma_pkg::ZERO) || (FTZ && clsB == fp_fma_pkg::SUB);
    assign cZero   = (clsC == fp_fma_pkg::ZERO) || (FTZ && clsC == fp_fma_pkg::SUB);

    // Priority-ordered special-case resolution; qNaN is the default hit result
    always_comb begin
      hit = 1'b1;
      inv = 1'b0;
      res = fp_fma_pkg::CANON_QNAN;
      if (aNan || bNan || cNan) begin
        inv = anySnan;
      end else if ((aInf && bZero) || (aZero && bInf)) begin
        inv = 1'b1;
      end else if ((aInf || bInf) && cInf && (sC != sp)) begin
        inv = 1'b1;
      end else if (aInf || bInf) begin
        res = {sp, {EXP_WIDTH{1'b1}}, {CSIG_WIDTH{1'b0}}};
      end else if (cInf) begin
        res = c[i*CWIDTH +: CWIDTH];
      end else if ((aZero || bZero) && cZero) begin
        res = {sp & sC, {(CWIDTH-1){1'b0}}};
      end else begin
        hit = 1'b0;
        res = '0;
      end
    end

    assign hitComb[i]                   = hit;
    assign invComb[i]                   = inv;
    assign resComb[i*CWIDTH +: CWIDTH]  = res;
    assign laneInf[i] = special_hit[i] &&
                        (special_result[i*CWIDTH+CSIG_WIDTH +: EXP_WIDTH] == '1) &&
                        (special_result[i*CWIDTH +: CSIG_WIDTH] == '0);
  end

  logic                    stall;
  logic                    fire;
  logic [STAGES-1:0]       vPipe;
  logic [LANES-1:0]        hitPipe [STAGES];
  logic [LANES-1:0]        invPipe [STAGES];
  logic [LANES*CWIDTH-1:0] resPipe [STAGES];

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign fire     = out_valid & out_ready;

  // Whole pipe freezes on stall; data regs load only when a valid beat moves into them
  always_ff @(posedge clk) begin
    if (rst) begin
      vPipe <= '0;
      for (int s = 0; s < STAGES; s++) begin
        hitPipe[s] <= '0;
        invPipe[s] <= '0;
        resPipe[s] <= '0;
      end
    end else if (!stall) begin
      vPipe[0] <= in_valid;
      if (in_valid) begin
        hitPipe[0] <= hitComb;
        invPipe[0] <= invComb;
        resPipe[0] <= resComb;
      end
      for (int s = 1; s < STAGES; s++) begin
        vPipe[s] <= vPipe[s-1];
        if (vPipe[s-1]) begin
          hitPipe[s] <= hitPipe[s-1];
          invPipe[s] <= invPipe[s-1];
          resPipe[s] <= resPipe[s-1];
        end
      end
    end
  end

  assign out_valid      = vPipe[STAGES-1];
  assign special_hit    = hitPipe[STAGES-1];
  assign lane_invalid   = invPipe[STAGES-1];
  assign special_result = resPipe[STAGES-1];

  // Exception state accumulates as beats leave; clear wins over a same-cycle event
  always_ff @(posedge clk) begin
    if (rst || clear_flags) begin
      sticky_invalid <= 1'b0;
      sticky_inf     <= 1'b0;
      invalid_count  <= '0;
    end else if (fire) begin
      sticky_invalid <= sticky_invalid | (|lane_invalid);
      sticky_inf     <= sticky_inf | (|laneInf);
      if ((|lane_invalid) && !(&invalid_count)) begin
        invalid_count <= invalid_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp_fma_special_pipe.sv
// tb/tb_fp_fma_special_pipe.sv - directed self-checking bench for fp_fma_special_pipe
module tb_fp_fma_special_pipe;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  a;
  logic [63:0]  b;
  logic [127:0] c;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   special_hit;
  logic [127:0] special_result;
  logic [3:0]   lane_invalid;
  logic         clear_flags;
  logic         sticky_invalid;
  logic         sticky_inf;
  logic [7:0]   invalid_count;

  int nChecks = 0;
  int nPass   = 0;
  int expCount = 0;

  fp_fma_special_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready),
    .special_hit(special_hit), .special_result(special_result),
    .lane_invalid(lane_invalid), .clear_flags(clear_flags),
    .sticky_invalid(sticky_invalid), .sticky_inf(sticky_inf),
    .invalid_count(invalid_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nChecks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else nPass++;
  endtask

  // Lane 0 carries the vector; lanes 1-3 hold 1.0*1.0+1.0
  function automatic logic [63:0] put16(input logic [15:0] v);
    return {16'h3F80, 16'h3F80, 16'h3F80, v};
  endfunction

  function automatic logic [127:0] put32(input logic [31:0] v);
    return {32'h3F800000, 32'h3F800000, 32'h3F800000, v};
  endfunction

  task automatic checkOut(input string tag, input logic [3:0] eHit, input logic [3:0] eInv,
                          input logic [127:0] eRes);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_hit"}, special_hit, eHit);
    check({tag, "_inv"}, lane_invalid, eInv);
    check({tag, "_res"}, special_result, eRes);
  endtask

  task automatic runBeat(input string tag, input logic [63:0] av, input logic [63:0] bv,
                         input logic [127:0] cv, input logic [3:0] eHit,
                         input logic [3:0] eInv, input logic [127:0] eRes);
    int lat;
    @(negedge clk);
    a = av; b = bv; c = cv; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 2);
    checkOut(tag, eHit, eInv, eRes);
    if (|eInv) expCount++;
    @(negedge clk);
    check({tag, "_cnt"}, invalid_count, expCount);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clear_flags = 1'b0;
    a = '0; b = '0; c = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_hit", special_hit, 4'h0);
    check("rst_res", special_result, 128'h0);
    check("rst_inv", lane_invalid, 4'h0);
    check("rst_sticky", {sticky_invalid, sticky_inf}, 2'b00);
    check("rst_cnt", invalid_count, 8'h00);
    check("rst_ready", in_ready, 1'b1);

    // Reset mid-flight drops the beat
    a = put16(16'h7F80); b = put16(16'h0000); c = put32(32'h3F800000); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid0", out_valid, 1'b0);
    @(negedge clk);
    check("midrst_valid1", out_valid, 1'b0);
    check("midrst_cnt", invalid_count, 8'h00);

    runBeat("infx0", put16(16'h7F80), put16(16'h0000), put32(32'h3F800000),
            4'h1, 4'h1, {96'h0, 32'h7FC00000});
    check("infx0_sticky_inv", sticky_invalid, 1'b1);
    check("infx0_sticky_inf", sticky_inf, 1'b0);
    runBeat("inf_minus_inf", put16(16'h7F80), put16(16'hBF80), put32(32'h7F800000),
            4'h1, 4'h1, {96'h0, 32'h7FC00000});
    runBeat("neg_inf", put16(16'h7F80), put16(16'hBF80), put32(32'hFF800000),
            4'h1, 4'h0, {96'h0, 32'hFF800000});
    check("neg_inf_sticky_inf", sticky_inf, 1'b1);
    runBeat("negzero", put16(16'h8000), put16(16'h3F80), put32(32'h80000000),
            4'h1, 4'h0, {96'h0, 32'h80000000});
    runBeat("poszero", put16(16'h8000), put16(16'h3F80), put32(32'h00000000),
            4'h1, 4'h0, {96'h0, 32'h00000000});
    runBeat("snan_l3", {16'h7F81, 16'h3F80, 16'h3F80, 16'h3F80}, put16(16'h3F80),
            put32(32'h3F800000), 4'h8, 4'h8, {32'h7FC00000, 96'h0});
    runBeat("qnan_c", put16(16'h3F80), put16(16'h3F80), put32(32'h7FC00001),
            4'h1, 4'h0, {96'h0, 32'h7FC00000});
    runBeat("c_inf", put16(16'h3F80), put16(16'h3F80), put32(32'hFF800000),
            4'h1, 4'h0, {96'h0, 32'hFF800000});
`ifdef FP_SPECIAL_FTZ_EN
    runBeat("sub_x_inf", put16(16'h0001), put16(16'h7F80), put32(32'h3F800000),
            4'h1, 4'h1, {96'h0, 32'h7FC00000});
    runBeat("zero_sub_c", put16(16'h0000), put16(16'h3F80), put32(32'h00000001),
            4'h1, 4'h0, {96'h0, 32'h00000000});
`else
    runBeat("sub_x_inf", put16(16'h0001), put16(16'h7F80), put32(32'h3F800000),
            4'h1, 4'h0, {96'h0, 32'h7F800000});
    runBeat("zero_sub_c", put16(16'h0000), put16(16'h3F80), put32(32'h00000001),
            4'h0, 4'h0, 128'h0);
`endif

    // Back-to-back beats into a stalled output
    @(negedge clk);
    out_ready = 1'b0;
    a = put16(16'h7F80); b = put16(16'h0000); c = put32(32'h3F800000); in_valid = 1'b1;
    @(negedge clk);
    a = put16(16'h7F80); b = put16(16'hBF80); c = put32(32'hFF800000);
    @(negedge clk);
    a = put16(16'h8000); b = put16(16'h3F80); c = put32(32'h80000000);
    check("stall_ready_low", in_ready, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checkOut($sformatf("stall_hold%0d", k), 4'h1, 4'h1, {96'h0, 32'h7FC00000});
      if (k < 2) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checkOut("drain_b2", 4'h1, 4'h0, {96'h0, 32'hFF800000});
    @(negedge clk);
    checkOut("drain_b3", 4'h1, 4'h0, {96'h0, 32'h80000000});
    @(negedge clk);
    check("drain_empty", out_valid, 1'b0);
    expCount++;
    check("drain_cnt", invalid_count, expCount);

    // Saturation: 300 invalid beats at full rate
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    check("clear_cnt", invalid_count, 8'h00);
    a = put16(16'h7F80); b = put16(16'h0000); c = put32(32'h3F800000); in_valid = 1'b1;
    repeat (300) @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("sat_cnt", invalid_count, 8'hFF);
    check("sat_sticky", sticky_invalid, 1'b1);

    // Clear coinciding with an invalid beat leaving the pipe
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("clr_evt_valid", out_valid, 1'b1);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    check("clr_evt_cnt", invalid_count, 8'h00);
    check("clr_evt_sticky", {sticky_invalid, sticky_inf}, 2'b00);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
